// File: rtl/hp_tracker_if.sv
// Signal bundle between game control / collision logic and the HP tracker.
// All inputs are single-cycle pulses or levels sampled on Clk; there is no valid/ready pair.
interface hp_tracker_if;
  logic       frame_tick;
  logic       round_start;
  logic       hit1;
  logic       special1;
  logic       hit2;
  logic       special2;
  logic [9:0] player_hp1;
  logic [9:0] player_hp2;
  logic       invuln1;
  logic       invuln2;
  logic       ko;
  logic [1:0] winner;
  logic [1:0] dbg_state;

  modport master (
    output frame_tick, round_start, hit1, special1, hit2, special2,
    input  player_hp1, player_hp2, invuln1, invuln2, ko, winner, dbg_state
  );

  modport slave (
    input  frame_tick, round_start, hit1, special1, hit2, special2,
    output player_hp1, player_hp2, invuln1, invuln2, ko, winner, dbg_state
  );
endinterface

// File: rtl/hp_tracker.sv
// Round health tracker: saturating damage, per-player frame-counted invulnerability,
// and an IDLE/FIGHT/KO round FSM reporting KO and winner.
module hp_tracker #(
  parameter int unsigned MAX_HP         = 200,
  parameter int unsigned HIT_DAMAGE     = 10,
  parameter int unsigned SPECIAL_DAMAGE = 30,
  parameter int unsigned INVULN_FRAMES  = 30
) (
  input logic         Clk,
  input logic         Reset,
  hp_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIGHT = 2'd1,
    S_KO    = 2'd2
  } state_t;

  localparam logic [9:0] MAX_V = 10'(MAX_HP);
  localparam logic [9:0] HIT_V = 10'(HIT_DAMAGE);
  localparam logic [9:0] SPC_V = 10'(SPECIAL_DAMAGE);
  localparam logic [7:0] INV_V = 8'(INVULN_FRAMES);

  state_t     state;
  logic [9:0] hp1, hp2;
  logic [7:0] cnt1, cnt2;
  logic       inv1, inv2;
  logic       ko_r;
  logic [1:0] win_r;

  logic [9:0] dmg1, dmg2, sat1, sat2, nhp1, nhp2;
  logic [7:0] ncnt1, ncnt2;
  logic       acc1, acc2;

  always_comb begin
    dmg1 = bus.special1 ? SPC_V : HIT_V;
    dmg2 = bus.special2 ? SPC_V : HIT_V;
    acc1 = (state == S_FIGHT) && bus.hit1 && (cnt1 == 8'd0);
    acc2 = (state == S_FIGHT) && bus.hit2 && (cnt2 == 8'd0);
    sat1 = (hp1 > dmg1) ? hp1 - dmg1 : 10'd0;
    sat2 = (hp2 > dmg2) ? hp2 - dmg2 : 10'd0;
    nhp1 = acc1 ? sat1 : hp1;
    nhp2 = acc2 ? sat2 : hp2;
    // A hit landing on a frame tick reloads the window rather than decrementing it.
    if (acc1)                                  ncnt1 = INV_V;
    else if (bus.frame_tick && cnt1 != 8'd0)   ncnt1 = cnt1 - 8'd1;
    else                                       ncnt1 = cnt1;
    if (acc2)                                  ncnt2 = INV_V;
    else if (bus.frame_tick && cnt2 != 8'd0)   ncnt2 = cnt2 - 8'd1;
    else                                       ncnt2 = cnt2;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      hp1   <= MAX_V;
      hp2   <= MAX_V;
      cnt1  <= 8'd0;
      cnt2  <= 8'd0;
      inv1  <= 1'b0;
      inv2  <= 1'b0;
      ko_r  <= 1'b0;
      win_r <= 2'b00;
    end else if (bus.round_start) begin
      state <= S_FIGHT;
      hp1   <= MAX_V;
      hp2   <= MAX_V;
      cnt1  <= 8'd0;
      cnt2  <= 8'd0;
      inv1  <= 1'b0;
      inv2  <= 1'b0;
      ko_r  <= 1'b0;
      win_r <= 2'b00;
    end else begin
      case (state)
        S_FIGHT: begin
          hp1  <= nhp1;
          hp2  <= nhp2;
          cnt1 <= ncnt1;
          cnt2 <= ncnt2;
          inv1 <= (ncnt1 != 8'd0);
          inv2 <= (ncnt2 != 8'd0);
          // winner bit 1 flags player 1 down, bit 0 flags player 2 down; both = draw.
          if (nhp1 == 10'd0 || nhp2 == 10'd0) begin
            state <= S_KO;
            ko_r  <= 1'b1;
            win_r <= {nhp1 == 10'd0, nhp2 == 10'd0};
          end
        end
        default: begin
          // IDLE and KO hold everything until round_start.
        end
      endcase
    end
  end

  assign bus.player_hp1 = hp1;
  assign bus.player_hp2 = hp2;
  assign bus.invuln1    = inv1;
  assign bus.invuln2    = inv2;
  assign bus.ko         = ko_r;
  assign bus.winner     = win_r;
  assign bus.dbg_state  = state;

endmodule
